// File: rtl/pagerank_mem_pkg.sv
// Shared definitions for the PageRank memory line path: default geometry,
// word-count derivations and the packer state encoding.
package pagerank_mem_pkg;

    localparam int FULL_WIDTH_DEF = 512;
    localparam int WIDTH_DEF      = 64;
    localparam int ADDR_W_DEF     = 32;

    function automatic int calc_num_words(input int full_width, input int width);
        return full_width / width;
    endfunction

    // A one-word line still needs a 1-bit index port to stay well formed.
    function automatic int calc_idx_w(input int num_words);
        return (num_words > 1) ? $clog2(num_words) : 1;
    endfunction

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } packer_state_e;

endpackage

// File: rtl/line_packer_if.sv
// Word-in / line-out bundle of the line packer; slave is the packer side,
// master is the word producer / line consumer side.
interface line_packer_if
    import pagerank_mem_pkg::*;
#(
    parameter int FULL_WIDTH = FULL_WIDTH_DEF,
    parameter int WIDTH      = WIDTH_DEF,
    parameter int ADDR_W     = ADDR_W_DEF
);
    localparam int NUM_WORDS = calc_num_words(FULL_WIDTH, WIDTH);
    localparam int IDX_W     = calc_idx_w(NUM_WORDS);

    logic                    in_valid;
    logic                    in_ready;
    logic [ADDR_W-1:0]       in_line_addr;
    logic [IDX_W-1:0]        in_idx;
    logic [WIDTH-1:0]        in_data;
    logic                    flush;
    logic                    out_valid;
    logic                    out_ready;
    logic [ADDR_W-1:0]       out_line_addr;
    logic [0:FULL_WIDTH-1]   out_line;
    logic [NUM_WORDS-1:0]    out_mask;
    logic                    empty;

    modport slave (
        input  in_valid, in_line_addr, in_idx, in_data, flush, out_ready,
        output in_ready, out_valid, out_line_addr, out_line, out_mask, empty
    );

    modport master (
        output in_valid, in_line_addr, in_idx, in_data, flush, out_ready,
        input  in_ready, out_valid, out_line_addr, out_line, out_mask, empty
    );

endinterface

// File: rtl/line_packer.sv
// Gathers indexed words into one memory line and emits it with its address
// and word-valid mask; a one-word pending register absorbs a line change.
module line_packer
    import pagerank_mem_pkg::*;
#(
    parameter int FULL_WIDTH = FULL_WIDTH_DEF,
    parameter int WIDTH      = WIDTH_DEF,
    parameter int ADDR_W     = ADDR_W_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    line_packer_if.slave  bus
);
    localparam int NUM_WORDS = calc_num_words(FULL_WIDTH, WIDTH);
    localparam int IDX_W     = calc_idx_w(NUM_WORDS);

    packer_state_e          state_q, state_d;
    logic [0:FULL_WIDTH-1]  line_q, line_d;
    logic [NUM_WORDS-1:0]   mask_q, mask_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;

    logic                   pend_valid_q, pend_valid_d;
    logic [ADDR_W-1:0]      pend_addr_q, pend_addr_d;
    logic [IDX_W-1:0]       pend_idx_q, pend_idx_d;
    logic [WIDTH-1:0]       pend_data_q, pend_data_d;

    logic                   in_ready_w;
    logic                   accept;
    logic                   wr_en;
    logic                   clr;
    logic [IDX_W-1:0]       wr_idx;
    logic [WIDTH-1:0]       wr_data;

    // in_ready is a pure function of registered state, never of in_valid.
    assign in_ready_w = (state_q != DRAIN);
    assign accept     = bus.in_valid && in_ready_w;

    // NOTE: every variable written here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        line_d       = line_q;
        mask_d       = mask_q;
        addr_d       = addr_q;
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        pend_idx_d   = pend_idx_q;
        pend_data_d  = pend_data_q;
        wr_en        = 1'b0;
        clr          = 1'b0;
        wr_idx       = bus.in_idx;
        wr_data      = bus.in_data;

        case (state_q)
            EMPTY: begin
                if (accept) begin
                    wr_en  = 1'b1;
                    addr_d = bus.in_line_addr;
                end
            end
            FILL: begin
                if (accept) begin
                    if (bus.in_line_addr == addr_q) begin
                        wr_en = 1'b1;
                    end else begin
                        pend_valid_d = 1'b1;
                        pend_addr_d  = bus.in_line_addr;
                        pend_idx_d   = bus.in_idx;
                        pend_data_d  = bus.in_data;
                        state_d      = DRAIN;
                    end
                end else if (bus.flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.out_ready) begin
                    clr = 1'b1;
                    if (pend_valid_q) begin
                        wr_en        = 1'b1;
                        wr_idx       = pend_idx_q;
                        wr_data      = pend_data_q;
                        addr_d       = pend_addr_q;
                        pend_valid_d = 1'b0;
                    end else begin
                        state_d = EMPTY;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase

        if (clr) begin
            line_d = '0;
            mask_d = '0;
        end

        // A written word always leaves the line non-empty: drain once the
        // mask is complete or a flush is requested, otherwise keep filling.
        if (wr_en) begin
            for (int k = 0; k < NUM_WORDS; k++) begin
                if (IDX_W'(k) == wr_idx) begin
                    line_d[k*WIDTH +: WIDTH] = wr_data;
                end
            end
            mask_d[wr_idx] = 1'b1;
            state_d        = (&mask_d || bus.flush) ? DRAIN : FILL;
        end
    end

    // NOTE: the line buffer is reset along with the control state because the
    // emitted line must read all-zero after reset, not just be masked off.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            line_q       <= '0;
            mask_q       <= '0;
            addr_q       <= '0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_idx_q   <= '0;
            pend_data_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q      <= state_d;
            line_q       <= line_d;
            mask_q       <= mask_d;
            addr_q       <= addr_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            pend_idx_q   <= pend_idx_d;
            pend_data_q  <= pend_data_d;
        end
    end

    assign bus.in_ready      = in_ready_w;
    assign bus.out_valid     = (state_q == DRAIN);
    assign bus.out_line      = line_q;
    assign bus.out_mask      = mask_q;
    assign bus.out_line_addr = addr_q;
    assign bus.empty         = (state_q == EMPTY) && !pend_valid_q;

endmodule

// File: tb/tb_line_packer.sv
// Directed bench for line_packer: full line, flush, line change, backpressure,
// duplicate index and reset mid-fill, each with hand-computed expectations.
module tb_line_packer;

    localparam int FW = 512;
    localparam int W  = 64;
    localparam int AW = 32;

    typedef logic [0:FW-1] line_t;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    line_packer_if #(.FULL_WIDTH(FW), .WIDTH(W), .ADDR_W(AW)) bus ();

    line_packer #(.FULL_WIDTH(FW), .WIDTH(W), .ADDR_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic line_t put_word(input line_t l, input int k, input logic [W-1:0] v);
        line_t r;
        r = l;
        r[k*W +: W] = v;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [AW-1:0] a, input logic [2:0] i, input logic [W-1:0] d);
        bus.in_valid     = 1'b1;
        bus.in_line_addr = a;
        bus.in_idx       = i;
        bus.in_data      = d;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
        checks++; if (bus.out_mask !== 8'h00) begin errors++; $display("FAIL reset_mask: got %h want 00", bus.out_mask); end
        checks++; if (bus.out_line !== '0) begin errors++; $display("FAIL reset_line: got %h want 0", bus.out_line); end
        checks++; if (bus.out_line_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", bus.out_line_addr); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_full_line();
        line_t exp;
        exp = '0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL full_early_valid[%0d]: got %b want 0", k, bus.out_valid); end
            send(32'h10, 3'(k), 64'h1000 + 64'(k));
            exp = put_word(exp, k, 64'h1000 + 64'(k));
        end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL full_valid: got %b want 1", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b want 0", bus.in_ready); end
        checks++; if (bus.out_line_addr !== 32'h10) begin errors++; $display("FAIL full_addr: got %h want 10", bus.out_line_addr); end
        checks++; if (bus.out_mask !== 8'hFF) begin errors++; $display("FAIL full_mask: got %h want ff", bus.out_mask); end
        checks++; if (bus.out_line !== exp) begin errors++; $display("FAIL full_line: got %h want %h", bus.out_line, exp); end
        checks++; if (bus.out_line[7*W +: W] !== 64'h1007) begin errors++; $display("FAIL full_word7: got %h want 1007", bus.out_line[7*W +: W]); end
        step();
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL full_empty_after: got %b want 1", bus.empty); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL full_valid_after: got %b want 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL full_in_ready_after: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_partial_flush();
        line_t exp;
        exp = '0;
        exp = put_word(exp, 2, 64'hAA);
        exp = put_word(exp, 5, 64'hBB);
        bus.out_ready = 1'b1;
        send(32'h20, 3'd2, 64'hAA);
        send(32'h20, 3'd5, 64'hBB);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL partial_no_valid: got %b want 0", bus.out_valid); end
        bus.flush = 1'b1;
        step();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL partial_valid: got %b want 1", bus.out_valid); end
        checks++; if (bus.out_mask !== 8'h24) begin errors++; $display("FAIL partial_mask: got %h want 24", bus.out_mask); end
        checks++; if (bus.out_line_addr !== 32'h20) begin errors++; $display("FAIL partial_addr: got %h want 20", bus.out_line_addr); end
        checks++; if (bus.out_line !== exp) begin errors++; $display("FAIL partial_line: got %h want %h", bus.out_line, exp); end
        step();
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL partial_empty: got %b want 1", bus.empty); end
        bus.flush = 1'b0;
    endtask

    task automatic test_line_change();
        line_t exp1;
        line_t exp2;
        exp1 = put_word('0, 1, 64'h11);
        exp2 = put_word('0, 0, 64'h22);
        bus.out_ready = 1'b0;
        send(32'h30, 3'd1, 64'h11);
        send(32'h31, 3'd0, 64'h22);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL chg_valid1: got %b want 1", bus.out_valid); end
        checks++; if (bus.out_line_addr !== 32'h30) begin errors++; $display("FAIL chg_addr1: got %h want 30", bus.out_line_addr); end
        checks++; if (bus.out_mask !== 8'h02) begin errors++; $display("FAIL chg_mask1: got %h want 02", bus.out_mask); end
        checks++; if (bus.out_line !== exp1) begin errors++; $display("FAIL chg_line1: got %h want %h", bus.out_line, exp1); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL chg_in_ready: got %b want 0", bus.in_ready); end
        checks++; if (bus.empty !== 1'b0) begin errors++; $display("FAIL chg_empty: got %b want 0", bus.empty); end
        bus.out_ready = 1'b1;
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL chg_fill_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.out_line_addr !== 32'h31) begin errors++; $display("FAIL chg_fill_addr: got %h want 31", bus.out_line_addr); end
        checks++; if (bus.out_mask !== 8'h01) begin errors++; $display("FAIL chg_fill_mask: got %h want 01", bus.out_mask); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL chg_fill_in_ready: got %b want 1", bus.in_ready); end
        bus.flush = 1'b1;
        step();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL chg_valid2: got %b want 1", bus.out_valid); end
        checks++; if (bus.out_line_addr !== 32'h31) begin errors++; $display("FAIL chg_addr2: got %h want 31", bus.out_line_addr); end
        checks++; if (bus.out_line !== exp2) begin errors++; $display("FAIL chg_line2: got %h want %h", bus.out_line, exp2); end
        step();
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL chg_empty_end: got %b want 1", bus.empty); end
        bus.flush = 1'b0;
    endtask

    task automatic test_backpressure();
        line_t exp;
        exp = '0;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            send(32'h50, 3'(k), 64'h5000 + 64'(k));
            exp = put_word(exp, k, 64'h5000 + 64'(k));
        end
        // A word offered while draining must not be taken.
        bus.in_valid     = 1'b1;
        bus.in_line_addr = 32'h50;
        bus.in_idx       = 3'd3;
        bus.in_data      = 64'hDEAD;
        for (int c = 0; c < 5; c++) begin
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b want 1", c, bus.out_valid); end
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b want 0", c, bus.in_ready); end
            checks++; if (bus.out_line !== exp) begin errors++; $display("FAIL bp_line[%0d]: got %h want %h", c, bus.out_line, exp); end
            checks++; if (bus.out_mask !== 8'hFF) begin errors++; $display("FAIL bp_mask[%0d]: got %h want ff", c, bus.out_mask); end
            checks++; if (bus.out_line_addr !== 32'h50) begin errors++; $display("FAIL bp_addr[%0d]: got %h want 50", c, bus.out_line_addr); end
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        checks++; if (bus.out_line !== exp) begin errors++; $display("FAIL bp_line_hs: got %h want %h", bus.out_line, exp); end
        step();
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL bp_empty: got %b want 1", bus.empty); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_after: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_duplicate();
        line_t exp;
        exp = put_word('0, 4, 64'hB);
        bus.out_ready = 1'b1;
        send(32'h40, 3'd4, 64'hA);
        send(32'h40, 3'd4, 64'hB);
        bus.flush = 1'b1;
        step();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL dup_valid: got %b want 1", bus.out_valid); end
        checks++; if (bus.out_mask !== 8'h10) begin errors++; $display("FAIL dup_mask: got %h want 10", bus.out_mask); end
        checks++; if (bus.out_line !== exp) begin errors++; $display("FAIL dup_line: got %h want %h", bus.out_line, exp); end
        step();
        bus.flush = 1'b0;
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL dup_empty: got %b want 1", bus.empty); end
    endtask

    task automatic test_reset_mid_fill();
        bus.out_ready = 1'b1;
        send(32'h60, 3'd0, 64'h600);
        send(32'h60, 3'd1, 64'h601);
        send(32'h60, 3'd2, 64'h602);
        checks++; if (bus.out_mask !== 8'h07) begin errors++; $display("FAIL rmf_mask_before: got %h want 07", bus.out_mask); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rmf_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL rmf_empty: got %b want 1", bus.empty); end
        checks++; if (bus.out_mask !== 8'h00) begin errors++; $display("FAIL rmf_mask: got %h want 00", bus.out_mask); end
        bus.flush = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rmf_flush_valid[%0d]: got %b want 0", c, bus.out_valid); end
        end
        bus.flush = 1'b0;
    endtask

    initial begin
        errors           = 0;
        checks           = 0;
        rst_n            = 1'b0;
        bus.in_valid     = 1'b0;
        bus.in_line_addr = '0;
        bus.in_idx       = '0;
        bus.in_data      = '0;
        bus.flush        = 1'b0;
        bus.out_ready    = 1'b0;

        test_reset();
        test_full_line();
        test_partial_flush();
        test_line_change();
        test_backpressure();
        test_duplicate();
        test_reset_mid_fill();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/line_packer.md
Name: line_packer

Overview:
- Write-side counterpart of the per-word line slicer: gathers WIDTH-bit words (e.g. updated rank values), each tagged with a line address and a word index, into one FULL_WIDTH-bit memory line.
- Emits the completed line, with its address and a word-valid mask, to the memory-write path over a valid/ready handshake.
- Holds one line buffer plus a one-word pending register, so a line-address change never drops a word.

Parameters:
- FULL_WIDTH, 512, memory line width in bits
- WIDTH, 64, word width in bits; FULL_WIDTH must be an integer multiple of WIDTH
- ADDR_W, 32, line address width
- Derived (localparams, not overridable): NUM_WORDS = FULL_WIDTH/WIDTH; IDX_W = $clog2(NUM_WORDS)

Ports:
- clk, input, 1, clock
- rst_n, input, 1, synchronous active-low reset
- in_valid, input, 1, word offered
- in_ready, output, 1, word accepted when in_valid && in_ready
- in_line_addr, input, ADDR_W, target line address
- in_idx, input, IDX_W, word index within the line
- in_data, input, WIDTH, word value
- flush, input, 1, level request to emit a partial line
- out_valid, output, 1, line available
- out_ready, input, 1, consumer takes the line when out_valid && out_ready
- out_line_addr, output, ADDR_W, address of the emitted line
- out_line, output, [0:FULL_WIDTH-1], assembled line
- out_mask, output, NUM_WORDS, bit i set = word i written
- empty, output, 1, no buffered or pending data and out_valid low

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n, sampled at the clk edge.
- Reset effects:
  - state goes to EMPTY; out_valid=0; out_mask=0; out_line=0; out_line_addr=0; pending cleared; empty=1.
  - Reset asserted mid-fill or mid-drain discards all data; no partial line is emitted.
- Word placement:
  - word k occupies out_line[WIDTH*k +: WIDTH], i.e. bits WIDTH*k .. WIDTH*k+WIDTH-1 of the ascending vector.
  - Slicing the emitted line at index k returns exactly the word written at k.
  - Unwritten words read 0.
- States:
  - EMPTY
    - in_ready=1.
    - An accepted word loads the buffer, sets the line address, and sets mask bit in_idx.
    - Next state is FILL, or DRAIN if the mask is now full or flush is high in the same cycle.
    - flush with no word accepted is ignored.
  - FILL
    - in_ready=1.
    - Accepted word with the same line address: write the word (duplicate index overwrites, last write wins) and set its mask bit. If the mask becomes all-ones, or flush is high, go to DRAIN.
    - Accepted word with a different line address: store it in the pending register; go to DRAIN. That word is not merged into the line being drained.
    - flush high with no word accepted: go to DRAIN with the partial mask.
  - DRAIN
    - out_valid=1; in_ready=0.
    - out_line, out_mask and out_line_addr are held stable until the handshake completes.
    - On out_valid && out_ready, clear the buffer and mask, then:
      - pending word present: load it into the buffer (mask = its bit) and clear pending; go to FILL, or directly to DRAIN if flush is high.
      - otherwise go to EMPTY.
- Latency: out_valid rises the cycle after the completing word (or the flush) is accepted. Throughput is at most one line per NUM_WORDS+1 cycles.
- in_ready:
  - Registered-state function only; it never depends on in_valid or in_data.
  - Low throughout DRAIN, including the handshake cycle. The first new word is accepted the cycle after the handshake.
- flush:
  - Level-sensitive, no acknowledge.
  - The requester holds it until empty=1; this guarantees the pending word also drains.
- empty: 1 only in EMPTY with pending clear.

Decomposition:
- Shared package pagerank_mem_pkg holds:
  - default FULL_WIDTH, WIDTH, ADDR_W;
  - the NUM_WORDS and IDX_W derivations;
  - the packer state enum {EMPTY, FILL, DRAIN}.
- The line slicer and line_packer both import it, so the word ordering is defined once.
- No sub-module is needed. The word-insert write-enable decode stays inline.

Test Plan (FULL_WIDTH=512, WIDTH=64, ADDR_W=32):
1. Full line: words 0..7 at line 0x10, data 0x1000+k, one per cycle, out_ready=1.
   - out_valid asserts the cycle after word 7; out_line_addr=0x10; out_mask=0xFF; word k slice = 0x1000+k.
   - in_ready=0 during DRAIN; empty=1 after the handshake.
2. Partial + flush: idx 2 = 0xAA and idx 5 = 0xBB at line 0x20, then flush=1.
   - out_mask=0x24; words 2/5 = 0xAA/0xBB; all other words = 0.
3. Line change: idx 1 @0x30 = 0x11, then idx 0 @0x31 = 0x22.
   - First emit: addr 0x30, mask 0x02.
   - Next cycle: FILL with addr 0x31, mask 0x01; in_ready=0 until the first handshake.
   - After flush: addr 0x31, word 0 = 0x22.
4. Backpressure: full line with out_ready=0 for 5 cycles.
   - out_valid, out_line, out_mask and out_line_addr stable throughout; in_ready=0.
   - Handshake on cycle 6; EMPTY next cycle.
5. Duplicate index: idx 4 = 0xA then idx 4 = 0xB at line 0x40, flush.
   - out_mask=0x10; word 4 = 0xB.
6. Reset mid-fill: 3 words accepted, then rst_n=0 for 1 cycle.
   - out_valid=0, empty=1, out_mask=0.
   - A subsequent flush produces no line.
